// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares the single write port of a small FIFO among N requesters with
// round-robin arbitration. The arbiter keeps its own copy of the FIFO
// occupancy and produces both the push strobe (from the registered grant) and
// the pop strobe (the consumer request gated by empty). Because of this, the
// FIFO can never overflow or underflow.
//
// Ports
//   clk                        sole clock, rising edge
//   rst                        asynchronous reset, active low; release is
//                              synchronous to clk
//   req[N-1:0]                 per-requester write request, level sensitive
//   gnt[N-1:0]                 registered one-hot grant; the push happens in
//                              the cycle the grant is high
//   push                       FIFO write strobe (OR of gnt)
//   pop_req                    consumer read request
//   pop                        FIFO read strobe (pop_req and not empty)
//   number_of_current_entries  registered occupancy count
//   full                       occupancy == DEPTH
//   empty                      occupancy == 0
//
// Parameters
//   N      number of requesters
//   DEPTH  FIFO capacity in entries
//   CNT_W  occupancy counter width; 2**CNT_W must exceed DEPTH
//
// Build option
//   FIFO_WRITE_ARB_SVA_EN  when defined, compiles in embedded assertions and
//                          occupancy cover points. Functional logic is the
//                          same either way.
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int N     = 5,
  parameter int DEPTH = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             push,
  input  logic             pop_req,
  output logic             pop,
  output logic [CNT_W-1:0] number_of_current_entries,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             space;
  logic [N-1:0]     gnt_nxt;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_nxt;

  // -------------------------------------------------------------------------
  // Occupancy
  // -------------------------------------------------------------------------
  assign push  = |gnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_C);
  // No fall-through: a push in the same cycle does not make an empty FIFO
  // readable.
  assign pop   = pop_req & ~empty;

  assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);

  // The grant issued now is pushed next cycle, when the count will already be
  // cnt_nxt, so space is judged on cnt_nxt rather than on cnt.
  assign space = (cnt_nxt < DEPTH_C);

  assign number_of_current_entries = cnt;

  // -------------------------------------------------------------------------
  // Round-robin grant selection
  // Search starts one past the last winner and wraps, so the most recent
  // winner has the lowest priority on the next arbitration.
  // -------------------------------------------------------------------------
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] sel;

    gnt_nxt  = '0;
    last_nxt = last;
    found    = 1'b0;
    sel      = '0;

    if (space) begin
      for (int k = 1; k <= N; k++) begin
        sel = IDX_W'((int'(last) + k) % N);
        if (!found && req[sel]) begin
          found        = 1'b1;
          gnt_nxt[sel] = 1'b1;
          last_nxt     = sel;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // Clearing gnt asynchronously also kills push immediately, so an in-flight
  // grant is cancelled by reset rather than completed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      gnt  <= '0;
      last <= LAST_RST;
    end else begin
      cnt  <= cnt_nxt;
      gnt  <= gnt_nxt;
      last <= last_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Embedded checks
  // -------------------------------------------------------------------------
`ifdef FIFO_WRITE_ARB_SVA_EN
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(gnt));

  for (genvar i = 0; i < N; i++) begin : g_gnt_req
    a_gnt_after_req : assert property (@(posedge clk) disable iff (!rst)
      gnt[i] |-> $past(req[i]));
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
    cnt <= DEPTH_C);

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst)
    !(pop && empty));

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    !(push && full));

  for (genvar v = 0; v <= DEPTH; v++) begin : g_cnt_cov
    c_occupancy : cover property (@(posedge clk) disable iff (!rst)
      cnt == CNT_W'(v));
  end
`else
  // Assertions and cover points are left out of this build.
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;

  localparam int N     = 5;
  localparam int DEPTH = 6;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic             push;
  logic             pop_req;
  logic             pop;
  logic [CNT_W-1:0] number_of_current_entries;
  logic             full;
  logic             empty;

  fifo_write_arbiter #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .req                       (req),
    .gnt                       (gnt),
    .push                      (push),
    .pop_req                   (pop_req),
    .pop                       (pop),
    .number_of_current_entries (number_of_current_entries),
    .full                      (full),
    .empty                     (empty)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model state: occupancy, grant currently on the bus, last winner
  int           m_cnt;
  logic [N-1:0] m_gnt;
  int           m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_gnt  = '0;
    m_last = N - 1;
  endtask

  // One clock cycle: apply inputs after the falling edge, check all outputs
  // against the model, then advance the model across the rising edge.
  task automatic tick(input logic [N-1:0] r, input logic p);
    int           nxt;
    int           l;
    int           idx;
    logic [N-1:0] g;
    logic         m_pop;
    @(negedge clk);
    req     = r;
    pop_req = p;
    #1;
    m_pop = p && (m_cnt > 0);
    chk("gnt",     32'(gnt),                       32'(m_gnt));
    chk("onehot",  32'($countones(gnt) <= 1),      32'(1));
    chk("push",    32'(push),                      32'(m_gnt != '0));
    chk("pop",     32'(pop),                       32'(m_pop));
    chk("count",   32'(number_of_current_entries), 32'(m_cnt));
    chk("full",    32'(full),                      32'(m_cnt == DEPTH));
    chk("empty",   32'(empty),                     32'(m_cnt == 0));
    nxt = m_cnt + ((m_gnt != '0) ? 1 : 0) - (m_pop ? 1 : 0);
    g   = '0;
    l   = m_last;
    if (nxt < DEPTH) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (r[idx]) begin
          g[idx] = 1'b1;
          l      = idx;
          break;
        end
      end
    end
    @(posedge clk);
    m_cnt  = nxt;
    m_gnt  = g;
    m_last = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    req     = '0;
    pop_req = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),                       32'(0));
    chk("rst_count", 32'(number_of_current_entries), 32'(0));
    chk("rst_empty", 32'(empty),                     32'(1));
    chk("rst_full",  32'(full),                      32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Reset asserted between clock edges, with outputs checked before any edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt",   32'(gnt),                       32'(0));
    chk("arst_push",  32'(push),                      32'(0));
    chk("arst_count", 32'(number_of_current_entries), 32'(0));
    chk("arst_empty", 32'(empty),                     32'(1));
    req     = '0;
    pop_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  int order_q[$];
  int exp_order[6] = '{0, 1, 2, 3, 4, 0};
  int n_grants;

  initial begin
    rst     = 1'b0;
    req     = '0;
    pop_req = 1'b0;
    model_reset();

    // 1: reset then idle, pop while empty
    do_reset();
    repeat (4) tick('0, 1'b1);

    // 2: single one-cycle request
    tick(5'b00100, 1'b0);
    #1 chk("t2_gnt", 32'(gnt), 32'(5'b00100));
    tick('0, 1'b0);
    #1 chk("t2_count", 32'(number_of_current_entries), 32'(1));
    repeat (3) tick('0, 1'b1);

    // 3: round-robin rotation under full request with continuous pops
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick(5'b11111, 1'b1);
      #1;
      for (int b = 0; b < N; b++)
        if (gnt[b]) order_q.push_back(b);
    end
    for (int i = 0; i < 6; i++)
      chk("t3_order", 32'((i < order_q.size()) ? order_q[i] : -1), 32'(exp_order[i]));

    // 4: fill and block, then one pop frees exactly one slot
    do_reset();
    n_grants = 0;
    for (int c = 0; c < 10; c++) begin
      tick(5'b00011, 1'b0);
      #1 if (push) n_grants++;
    end
    chk("t4_grants", 32'(n_grants), 32'(6));
    chk("t4_full",   32'(full),     32'(1));
    n_grants = 0;
    tick(5'b00011, 1'b1);
    #1 if (push) n_grants++;
    for (int c = 0; c < 4; c++) begin
      tick(5'b00011, 1'b0);
      #1 if (push) n_grants++;
    end
    chk("t4_regrant", 32'(n_grants), 32'(1));
    chk("t4_count",   32'(number_of_current_entries), 32'(6));

    // 5: count held while pushing and popping together
    do_reset();
    tick(5'b00001, 1'b0);
    tick(5'b00010, 1'b0);
    tick(5'b00100, 1'b0);
    tick(5'b01000, 1'b0);
    for (int c = 0; c < 4; c++) tick(5'b11111, 1'b1);
    #1 chk("t5_count", 32'(number_of_current_entries), 32'(3));

    // 6: async reset with gnt=01000 and count=4
    do_reset();
    tick(5'b00111, 1'b0);
    tick(5'b00111, 1'b0);
    tick(5'b00111, 1'b0);
    tick(5'b00111, 1'b0);
    tick(5'b01000, 1'b0);
    @(negedge clk);
    req = '0;
    #1;
    chk("t6_pre_gnt",   32'(gnt),                       32'(5'b01000));
    chk("t6_pre_count", 32'(number_of_current_entries), 32'(4));
    #1 rst = 1'b0;
    #1;
    chk("t6_gnt",   32'(gnt),                       32'(0));
    chk("t6_push",  32'(push),                      32'(0));
    chk("t6_count", 32'(number_of_current_entries), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    tick(5'b11111, 1'b0);
    #1 chk("t6_first", 32'(gnt), 32'(5'b00001));

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      logic         p;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      p = ($urandom_range(0, 99) < 45);
      tick(r, p);
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the 6-entry FIFO among N requesters using round-robin arbitration.
- Grants are registered and one-hot: gnt[i] rises exactly one cycle after req[i] is sampled.
- Tracks FIFO occupancy internally and drives the pop strobe to the FIFO, so the FIFO can never overflow or underflow.
- Exports number_of_current_entries for the FIFO coverage checker.

Parameters:
- N, 5, number of requesters.
- DEPTH, 6, FIFO capacity in entries.
- CNT_W, 3, occupancy counter width; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low (asserted at 0); state clears immediately, release is synchronous to clk.
- req  input  N  per-requester write request; level-sensitive, may drop at any time.
- gnt  output  N  registered one-hot write grant; a grant means the FIFO push happens this cycle.
- push  output  1  FIFO write strobe, equal to the OR of gnt.
- pop_req  input  1  consumer read request.
- pop  output  1  FIFO read strobe, equal to pop_req AND NOT empty (combinational).
- number_of_current_entries  output  CNT_W  registered occupancy count.
- full  output  1  high when number_of_current_entries == DEPTH.
- empty  output  1  high when number_of_current_entries == 0.

Behaviour:
- Reset values: gnt=0, push=0, number_of_current_entries=0, empty=1, full=0. Priority pointer last=N-1, so req[0] has highest priority first.
- Occupancy:
  - cnt_nxt = cnt + push - pop, evaluated every cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - There is no fall-through: pop is blocked while empty, even when push is high in the same cycle.
- Space check: space = (cnt_nxt < DEPTH). This uses the next-cycle count, so a grant issued now lands when a slot is free.
- Grant generation, evaluated each cycle:
  - If space and |req: gnt_nxt = one-hot of the first set req bit, searching (last+1) mod N upward with wrap. last is then updated to that index.
  - Otherwise gnt_nxt = 0 and last is unchanged.
  - gnt is registered from gnt_nxt, giving a latency of 1 cycle from req to gnt.
- Grant lifetime:
  - Each grant lasts exactly one cycle and moves one entry.
  - A requester holding req continuously gets back-to-back grants only if it is the sole requester.
  - With several requesters, grants rotate fairly. Worst-case wait is N-1 grant cycles once space is available.
- Full behaviour:
  - Grants stop while space is 0 and resume the cycle after a pop makes space.
  - At count=DEPTH-1 with a grant in flight and no pop, no further grant is issued.
- Requests that drop: a req dropped before sampling is not granted. A grant already registered still completes; the requester must accept a grant one cycle after asserting req.
- Reset during operation: all state clears asynchronously. Any in-flight grant is cancelled, with no push in that cycle.
- Invariants: at most one gnt bit is set; number_of_current_entries <= DEPTH; push and full never occur in the same cycle.

Optional Feature:
- Macro: FIFO_WRITE_ARB_SVA_EN.
- When defined, embedded SVA checks are compiled in, all with disable iff (!rst):
  - gnt is one-hot or zero.
  - gnt[i] implies $past(req[i]).
  - number_of_current_entries <= DEPTH.
  - pop never fires while empty.
  - push never fires while full.
  - Cover points for each occupancy value 0..DEPTH.
- When undefined: no assertion code is present and the functional RTL is identical.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then release -> gnt=0, count=0, empty=1, full=0; pop_req=1 while empty -> pop=0, count stays 0.
2. Single request: req=5'b00100 for 1 cycle -> gnt=5'b00100 exactly one cycle later, push=1, count becomes 1 the following cycle.
3. Round-robin: req=5'b11111 held, pop_req=1 to keep space -> grant order 0,1,2,3,4,0, one per cycle, never two bits set.
4. Fill and block: req=5'b00011 held, no pop -> exactly 6 grants, then count=6, full=1 and no further gnt; one pop cycle -> exactly one new grant follows, and count returns to 6.
5. Simultaneous push/pop: count=3, grant in flight, pop_req=1 -> count remains 3 and empty/full stay 0.
6. Reset mid-operation: rst=0 asynchronously while gnt=5'b01000 and count=4 -> gnt and push drop immediately, count=0; after release, first grant with req=5'b11111 goes to requester 0.
